// File: rtl/bus_mul_seq.sv
// bus_mul_seq: parametrised radix-2 shift-add multiplier behind a byte-wide
// register bus. Operands A and B are written a byte at a time (MSB lane first),
// a start strobe launches an OP_W-step multiply, and the 2*OP_W-bit product is
// read back a byte at a time through a registered read port.
// OP_W must be a multiple of 8 in the range 8..64.
// Build option: define MUL_SIGNED_MODE_EN to add the signed_mode input and
// two's-complement multiplication; without it every operation is unsigned.

module bus_mul_seq #(
  parameter  int OP_W  = 16,
  localparam int NB    = OP_W / 8,
  localparam int SEL_W = (2 * NB > 2) ? $clog2(2 * NB) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       bus_in,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic             start,
`ifdef MUL_SIGNED_MODE_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [7:0]       bus_out
);

  localparam int ACC_W = 2 * OP_W + 1;
  localparam int CNT_W = $clog2(OP_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [OP_W-1:0]   a_q, a_d;
  logic [OP_W-1:0]   b_q, b_d;
  logic [OP_W-1:0]   mcand_q, mcand_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*OP_W-1:0] result_q, result_d;
  logic              neg_q, neg_d;
  logic [7:0]        bus_out_q, bus_out_d;

  logic              idle;
  logic              wr_accept;
  logic [OP_W-1:0]   a_mag;
  logic [OP_W-1:0]   b_mag;
  logic              neg_launch;
  logic [OP_W:0]     add_sum;
  logic [ACC_W-1:0]  acc_step;
  logic [2*OP_W-1:0] product;

  assign idle      = (state_q == IDLE);
  assign wr_accept = wr_en && idle && (int'(wr_sel) < 2 * NB);
  assign product   = acc_q[2*OP_W-1:0];

  assign busy    = busy_q;
  assign done    = done_q;
  assign bus_out = bus_out_q;

  // Byte-lane writes into the operand registers; lane 0 of each operand is its MSB.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (wr_accept) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_sel == SEL_W'(i))      a_d[(NB-1-i)*8 +: 8] = bus_in;
        if (wr_sel == SEL_W'(NB + i)) b_d[(NB-1-i)*8 +: 8] = bus_in;
      end
    end
  end

`ifdef MUL_SIGNED_MODE_EN
  // Signed launches iterate on magnitudes; the product sign is restored in FIN.
  always_comb begin
    a_mag      = a_q;
    b_mag      = b_q;
    neg_launch = 1'b0;
    if (signed_mode) begin
      if (a_q[OP_W-1]) a_mag = -a_q;
      if (b_q[OP_W-1]) b_mag = -b_q;
      neg_launch = a_q[OP_W-1] ^ b_q[OP_W-1];
    end
  end
`else
  // Unsigned-only build: operands feed the iteration unchanged.
  always_comb begin
    a_mag      = a_q;
    b_mag      = b_q;
    neg_launch = 1'b0;
  end
`endif

  // One radix-2 step: conditionally add the multiplicand into the upper half
  // (with a carry bit), then shift the accumulator right to retire a multiplier bit.
  always_comb begin
    add_sum = acc_q[ACC_W-1:OP_W] + {1'b0, mcand_q};
    if (acc_q[0]) acc_step = {add_sum, acc_q[OP_W-1:0]} >> 1;
    else          acc_step = acc_q >> 1;
  end

  // Control: launch from IDLE, OP_W iterations in RUN, publish result in FIN.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = done_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    neg_d    = neg_q;

    if (wr_accept) done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          mcand_d = a_mag;
          acc_d   = {{(OP_W + 1){1'b0}}, b_mag};
          cnt_d   = CNT_W'(OP_W);
          neg_d   = neg_launch;
        end
      end
      RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIN;
      end
      FIN: begin
        result_d = neg_q ? (-product) : product;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Readback mux: result lane 0 is the MSB; out-of-range selects read as zero.
  always_comb begin
    bus_out_d = 8'h00;
    for (int i = 0; i < 2 * NB; i++) begin
      if (rd_sel == SEL_W'(i)) bus_out_d = result_q[(2*NB-1-i)*8 +: 8];
    end
  end

  // State and datapath registers; reset aborts any in-flight multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      neg_q     <= 1'b0;
      bus_out_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      neg_q     <= neg_d;
      bus_out_q <= bus_out_d;
    end
  end

endmodule

// File: tb/tb_bus_mul_seq.sv
// tb_bus_mul_seq: exercises bus_mul_seq at OP_W=16 (main instance) and OP_W=24
// (wide instance). Expected products come from plain integer multiplication
// of the operand bytes the bench has written.

module tb_bus_mul_seq;

  localparam int OP_W    = 16;
  localparam int TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] bus_in;
  logic       wr_en;
  logic [1:0] wr_sel;
  logic       start;
  logic       signedMode;
  logic       busy;
  logic       done;
  logic [1:0] rd_sel;
  logic [7:0] bus_out;

  logic       wrEn24;
  logic [2:0] wrSel24;
  logic       start24;
  logic [2:0] rdSel24;
  logic       busy24;
  logic       done24;
  logic [7:0] busOut24;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cycle  = 0;
  int startCycle = 0;

  logic [7:0]  mdlBytes [0:3];
  bit          mdlBusy;
  bit          mdlDone;
  logic [31:0] mdlResult;
  logic [31:0] mdlPending;

  always #5 clk = ~clk;

  bus_mul_seq #(.OP_W(OP_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus_in      (bus_in),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .start       (start),
`ifdef MUL_SIGNED_MODE_EN
    .signed_mode (signedMode),
`endif
    .busy        (busy),
    .done        (done),
    .rd_sel      (rd_sel),
    .bus_out     (bus_out)
  );

  bus_mul_seq #(.OP_W(24)) dut24 (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus_in      (bus_in),
    .wr_en       (wrEn24),
    .wr_sel      (wrSel24),
    .start       (start24),
`ifdef MUL_SIGNED_MODE_EN
    .signed_mode (1'b0),
`endif
    .busy        (busy24),
    .done        (done24),
    .rd_sel      (rdSel24),
    .bus_out     (busOut24)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cycle++;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] mdlProduct(input logic [15:0] a, input logic [15:0] b, input logic sgn);
    longint pa;
    longint pb;
    if (sgn) begin
      pa = longint'(signed'(a));
      pb = longint'(signed'(b));
    end else begin
      pa = longint'(a);
      pb = longint'(b);
    end
    return 32'(pa * pb);
  endfunction

  function automatic logic [15:0] pickOp();
    logic [15:0] corner [0:3];
    corner[0] = 16'h0000;
    corner[1] = 16'hFFFF;
    corner[2] = 16'h8000;
    corner[3] = 16'h0001;
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  // One bus cycle on the main instance; the model accepts writes and starts only when idle.
  task automatic applyStimulus(input bit doWrite, input logic [1:0] sel, input logic [7:0] val, input bit doStart);
    bit wasBusy;
    wasBusy = mdlBusy;
    wr_en   = doWrite;
    wr_sel  = sel;
    bus_in  = val;
    start   = doStart;
    if (doStart && !wasBusy) begin
      mdlPending = mdlProduct({mdlBytes[0], mdlBytes[1]}, {mdlBytes[2], mdlBytes[3]}, signedMode);
      mdlBusy    = 1'b1;
      mdlDone    = 1'b0;
    end
    if (doWrite && !wasBusy) begin
      mdlBytes[sel] = val;
      mdlDone       = 1'b0;
    end
    tick();
    if (doStart && !wasBusy) startCycle = cycle;
    wr_en = 1'b0;
    start = 1'b0;
  endtask

  task automatic loadOps(input logic [15:0] a, input logic [15:0] b);
    applyStimulus(1'b1, 2'd0, a[15:8], 1'b0);
    applyStimulus(1'b1, 2'd1, a[7:0],  1'b0);
    applyStimulus(1'b1, 2'd2, b[15:8], 1'b0);
    applyStimulus(1'b1, 2'd3, b[7:0],  1'b0);
  endtask

  // Waits for done while optionally poking start/write (which must be ignored while busy).
  task automatic waitDone(input string tag, input int extraStartAt, input bit noise);
    bit held;
    held = 1'b1;
    while (done !== 1'b1 && (cycle - startCycle) < TIMEOUT) begin
      if (busy !== 1'b1) held = 1'b0;
      start  = ((cycle - startCycle) == extraStartAt) || (noise && ($urandom_range(0, 3) == 0));
      wr_en  = noise && ($urandom_range(0, 3) == 0);
      wr_sel = 2'($urandom_range(0, 3));
      bus_in = 8'($urandom);
      tick();
      start = 1'b0;
      wr_en = 1'b0;
    end
    checkOutput({tag, " latency"}, 64'(cycle - startCycle), 64'(OP_W + 1));
    checkOutput({tag, " busy held"}, 64'(held), 64'(1));
    checkOutput({tag, " busy at done"}, 64'(busy), 64'(0));
    mdlBusy   = 1'b0;
    mdlDone   = 1'b1;
    mdlResult = mdlPending;
  endtask

  task automatic readResult(output logic [31:0] got);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      tick();
      got[(3-i)*8 +: 8] = bus_out;
    end
  endtask

  task automatic write24(input logic [2:0] sel, input logic [7:0] val);
    wrEn24  = 1'b1;
    wrSel24 = sel;
    bus_in  = val;
    tick();
    wrEn24  = 1'b0;
  endtask

  task automatic load24(input logic [23:0] a, input logic [23:0] b);
    for (int i = 0; i < 3; i++) write24(3'(i), a[(2-i)*8 +: 8]);
    for (int i = 0; i < 3; i++) write24(3'(3 + i), b[(2-i)*8 +: 8]);
  endtask

  task automatic mul24(input string tag, input logic [47:0] expected);
    int lat;
    logic [47:0] got;
    logic [7:0]  oor;
    start24 = 1'b1;
    tick();
    start24 = 1'b0;
    lat = 0;
    while (done24 !== 1'b1 && lat < TIMEOUT) begin
      tick();
      lat++;
    end
    checkOutput({tag, " latency"}, 64'(lat), 64'(25));
    for (int i = 0; i < 8; i++) begin
      rdSel24 = 3'(i);
      tick();
      if (i < 6) got[(5-i)*8 +: 8] = busOut24;
      else begin
        oor = busOut24;
        checkOutput({tag, " out-of-range read"}, 64'(oor), 64'(0));
      end
    end
    checkOutput({tag, " result"}, 64'(got), 64'(expected));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    logic [31:0] got;
    logic [15:0] a;
    logic [15:0] b;
    logic [23:0] a24;
    logic [23:0] b24;

    rst_n = 1'b0;
    bus_in = 8'h00; wr_en = 1'b0; wr_sel = 2'd0; start = 1'b0; rd_sel = 2'd0; signedMode = 1'b0;
    wrEn24 = 1'b0; wrSel24 = 3'd0; start24 = 1'b0; rdSel24 = 3'd0;
    for (int i = 0; i < 4; i++) mdlBytes[i] = 8'h00;
    mdlBusy = 1'b0; mdlDone = 1'b0; mdlResult = 32'h0; mdlPending = 32'h0;

    // Reset state
    tick();
    tick();
    checkOutput("reset busy", 64'(busy), 64'(0));
    checkOutput("reset done", 64'(done), 64'(0));
    checkOutput("reset bus_out", 64'(bus_out), 64'(0));
    rst_n = 1'b1;
    tick();
    readResult(got);
    checkOutput("reset result", 64'(got), 64'(mdlResult));

    // 12 x 24 = 288
    loadOps(16'd12, 16'd24);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    checkOutput("12x24 busy after start", 64'(busy), 64'(1));
    waitDone("12x24", -1, 1'b0);
    checkOutput("12x24 done", 64'(done), 64'(mdlDone));
    readResult(got);
    checkOutput("12x24 result", 64'(got), 64'(mdlResult));
    checkOutput("12x24 bytes", 64'(got), 64'(32'h0000_0120));

    // FFFF x FFFF with writes attempted while busy
    loadOps(16'hFFFF, 16'hFFFF);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    applyStimulus(1'b1, 2'd0, 8'h12, 1'b0);
    applyStimulus(1'b1, 2'd1, 8'h34, 1'b0);
    waitDone("ffff", -1, 1'b0);
    readResult(got);
    checkOutput("ffff result", 64'(got), 64'(mdlResult));
    checkOutput("ffff literal", 64'(got), 64'(32'hFFFE_0001));

    // Relaunch with the held operands and a start pulse in the fifth RUN cycle
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    waitDone("ignored start", 4, 1'b0);
    readResult(got);
    checkOutput("operands held result", 64'(got), 64'(32'hFFFE_0001));

    // A new start after done drops done on the next edge
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    checkOutput("done drop on restart", 64'(done), 64'(mdlDone));
    checkOutput("busy on restart", 64'(busy), 64'(1));
    waitDone("restart", -1, 1'b0);

    // Asynchronous reset in the middle of a multiply
    rd_sel = 2'd0;
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    tick();
    tick();
    tick();
    checkOutput("pre-reset busy", 64'(busy), 64'(1));
    checkOutput("pre-reset bus_out", 64'(bus_out), 64'(mdlResult[31:24]));
    rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", 64'(busy), 64'(0));
    checkOutput("async reset done", 64'(done), 64'(0));
    checkOutput("async reset bus_out", 64'(bus_out), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mdlBytes[i] = 8'h00;
    mdlBusy = 1'b0; mdlDone = 1'b0; mdlResult = 32'h0;
    readResult(got);
    checkOutput("post-reset result", 64'(got), 64'(mdlResult));
    loadOps(16'd3, 16'd7);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    waitDone("3x7", -1, 1'b0);
    readResult(got);
    checkOutput("3x7 result", 64'(got), 64'(32'h0000_0015));

    // Same-edge write and start: multiply uses the old A, the write still lands
    applyStimulus(1'b1, 2'd1, 8'h05, 1'b1);
    waitDone("same-edge", -1, 1'b0);
    readResult(got);
    checkOutput("same-edge result", 64'(got), 64'(mdlResult));
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    waitDone("after same-edge", -1, 1'b0);
    readResult(got);
    checkOutput("new operand result", 64'(got), 64'(mdlResult));

`ifdef MUL_SIGNED_MODE_EN
    // Signed versus unsigned interpretation of the same operands
    loadOps(16'hFFFD, 16'd5);
    signedMode = 1'b1;
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    signedMode = 1'b0;
    waitDone("signed", -1, 1'b0);
    readResult(got);
    checkOutput("signed result", 64'(got), 64'(32'hFFFF_FFF1));
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    waitDone("unsigned", -1, 1'b0);
    readResult(got);
    checkOutput("unsigned result", 64'(got), 64'(32'h0004_FFF1));
`endif

    // Randomised operands with ignored traffic while busy
    for (int it = 0; it < 20; it++) begin
      a = pickOp();
      b = pickOp();
`ifdef MUL_SIGNED_MODE_EN
      signedMode = 1'($urandom_range(0, 1));
`endif
      applyStimulus(1'b1, 2'd0, a[15:8], 1'b0);
      checkOutput("done cleared by write", 64'(done), 64'(mdlDone));
      applyStimulus(1'b1, 2'd1, a[7:0],  1'b0);
      applyStimulus(1'b1, 2'd2, b[15:8], 1'b0);
      applyStimulus(1'b1, 2'd3, b[7:0],  1'b0);
      applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
      signedMode = 1'b0;
      waitDone("random", $urandom_range(0, 20), 1'b1);
      readResult(got);
      checkOutput("random result", 64'(got), 64'(mdlResult));
      checkOutput("done sticky", 64'(done), 64'(mdlDone));
    end

    // Wide instance: directed product, out-of-range writes and reads, then random
    load24(24'h123456, 24'h000010);
    write24(3'd6, 8'hFF);
    write24(3'd7, 8'hAA);
    mul24("w24 directed", 48'h0000_0123_4560);
    mul24("w24 rerun", 48'h0000_0123_4560);
    for (int it = 0; it < 3; it++) begin
      a24 = 24'($urandom);
      b24 = 24'($urandom);
      load24(a24, b24);
      mul24("w24 random", {24'h0, a24} * {24'h0, b24});
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
